mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Sequencer between the RISC execute stage and the 16x16 shift-add Multiplicador.
- Accepts one multiply request (operands plus destination register) over a valid/ready handshake.
- Waits for the multiplier to be idle, fires a single-cycle start, and waits for its done indication.
- Captures the low 16 product bits and presents them as a register-file writeback with backpressure.
- Also provides a zero-operand bypass, an rd=0 discard and a watchdog timeout.

Parameters:
WIDTH, 16, operand/product width (must match multiplier)
RD_W, 4, destination register address width
TIMEOUT, 64, max cycles in RUN before abort (must exceed multiplier latency)
ZERO_BYPASS, 1, 1 = skip multiplier when either operand is zero

Ports:
Clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_a  in  WIDTH  multiplicand
req_b  in  WIDTH  multiplier
req_rd  in  RD_W  destination register
mul_a  out  WIDTH  to Multiplicando; latched operand
mul_b  out  WIDTH  to Multiplicador; latched operand
mul_st  out  1  to St; one-cycle start pulse
mul_idle  in  1  from Idle
mul_done  in  1  from Done
mul_prod  in  WIDTH  from Produto
wb_valid  out  1  writeback valid
wb_rd  out  RD_W  writeback register address
wb_data  out  WIDTH  writeback data
wb_ack  in  1  register file accepted writeback
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset, synchronous on the Clk edge with rst=1, overrides everything:
  - state=IDLE.
  - op_a, op_b, rd, wb_data, wb_rd and the counter are cleared to 0.
  - mul_st, wb_valid and timeout_err are 0; req_ready is 1 the cycle after reset.
  - A reset mid-operation abandons the transaction with no writeback; the multiplier shares rst.
- Combinational outputs:
  - req_ready = (state==IDLE).
  - busy = !req_ready.
  - mul_a = op_a, mul_b = op_b, held stable from acceptance until the return to IDLE.
- IDLE:
  - On req_valid&&req_ready, latch req_a/req_b/req_rd.
  - If ZERO_BYPASS and (req_a==0 or req_b==0): wb_data<=0, then go to WB, or to IDLE if req_rd==0. mul_st is never asserted on this path.
  - Otherwise go to WAIT_IDLE.
- WAIT_IDLE: stay until mul_idle=1, then go to START.
- START: mul_st=1 for exactly this cycle; counter<=0; go to RUN.
- RUN:
  - mul_done=1: wb_data<=mul_prod, wb_rd<=rd; go to WB if rd!=0, else go to IDLE (result discarded; r0 is hardwired).
  - Else if counter==TIMEOUT-1: timeout_err=1 for one cycle, go to IDLE, no writeback.
  - Else counter+1.
  - mul_done in any other state is ignored.
- WB:
  - wb_valid=1, with wb_rd and wb_data held stable until wb_ack=1.
  - The ack cycle moves to IDLE; wb_valid is low the next cycle.
  - wb_ack outside WB is ignored.
- Product is mul_prod unmodified (low WIDTH bits of the full product); no sign handling.
- Latency, from the acceptance edge with the multiplier idle:
  - mul_st goes high 2 cycles later.
  - wb_valid goes high 1 cycle after the mul_done edge.
  - Bypass path: wb_valid goes high 1 cycle after acceptance.
- req_valid while busy is not accepted; a new request can be taken the cycle after the wb_ack cycle.

Test Plan:
- 7x7, rd=3, wb_ack tied high -> exactly one mul_st pulse, wb_valid with wb_rd=3 and wb_data=49, then req_ready=1.
- 65535x3, rd=5 -> wb_data=0xFFFD. 30000x4000, rd=7 -> wb_data=0x0E00 (low 16 bits of 120000000).
- 0x1234, rd=2 -> wb_valid 1 cycle after acceptance with wb_data=0; mul_st never high. 5x2, rd=0 -> mul_st pulses, no wb_valid, req_ready returns after done.
- wb_ack held low 10 cycles during 5x2, rd=4 -> wb_valid/wb_rd/wb_data stable at 1/4/10, req_ready=0 with req_valid=1 held, no second acceptance; ack -> IDLE.
- Multiplier model never asserts done -> timeout_err pulses after 64 RUN cycles, no wb_valid, req_ready=1. rst asserted 5 cycles into RUN -> all outputs 0, req_ready=1 next cycle, and a following 7x7 completes correctly with 49.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// Request, multiplier and writeback signal bundle for mul_issue_ctrl.
// The master modport is the controller; slave is the surrounding
// execute stage, shift-add multiplier and register file.
interface mul_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [RD_W-1:0]  req_rd;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_st;
  logic             mul_idle;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic             wb_valid;
  logic [RD_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ack;

  modport master (
    input  req_valid, req_a, req_b, req_rd, mul_idle, mul_done, mul_prod, wb_ack,
    output req_ready, mul_a, mul_b, mul_st, wb_valid, wb_rd, wb_data
  );

  modport slave (
    output req_valid, req_a, req_b, req_rd, mul_idle, mul_done, mul_prod, wb_ack,
    input  req_ready, mul_a, mul_b, mul_st, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Sequencer between the execute stage and the 16x16 shift-add multiplier.
// Takes one request at a time, starts the multiplier once it is idle,
// captures the low product bits and hands them to the register file.
// Zero operands bypass the multiplier; results for r0 are dropped; a
// watchdog aborts a multiply that never reports done.
module mul_issue_ctrl #(
  parameter int WIDTH       = 16,
  parameter int RD_W        = 4,
  parameter int TIMEOUT     = 64,
  parameter int ZERO_BYPASS = 1
) (
  input  logic              Clk,
  input  logic              rst,
  mul_issue_ctrl_if.master  bus,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_START,
    S_RUN,
    S_WB
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [RD_W-1:0]  rd;
  logic [WIDTH-1:0] wb_data_q;
  logic [RD_W-1:0]  wb_rd_q;
  logic [CNT_W-1:0] cnt;
  logic             req_ready;
  logic             accept;
  logic             bypass_hit;
  logic             mul_st;
  logic             wb_valid;

  assign req_ready  = (state == S_IDLE);
  assign busy       = !req_ready;
  assign accept     = bus.req_valid && req_ready;
  assign bypass_hit = (ZERO_BYPASS != 0) &&
                      ((bus.req_a == '0) || (bus.req_b == '0));

  assign bus.req_ready = req_ready;
  assign bus.mul_a     = op_a;
  assign bus.mul_b     = op_b;
  assign bus.mul_st    = mul_st;
  assign bus.wb_valid  = wb_valid;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode plus the per-state strobes (start, writeback, abort).
  always_comb begin
    state_n     = state;
    mul_st      = 1'b0;
    wb_valid    = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bypass_hit) state_n = (bus.req_rd == '0) ? S_IDLE : S_WB;
          else            state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (bus.mul_idle) state_n = S_START;
      end
      S_START: begin
        mul_st  = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        if (bus.mul_done) begin
          state_n = (rd != '0) ? S_WB : S_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_err = 1'b1;
          state_n     = S_IDLE;
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (bus.wb_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand/destination latch, watchdog counter and writeback capture.
  always_ff @(posedge Clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      rd        <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        op_a <= bus.req_a;
        op_b <= bus.req_b;
        rd   <= bus.req_rd;
        if (bypass_hit) begin
          wb_data_q <= '0;
          wb_rd_q   <= bus.req_rd;
        end
      end
      if (state == S_START) begin
        cnt <= '0;
      end else if (state == S_RUN && !bus.mul_done && cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_RUN && bus.mul_done) begin
        wb_data_q <= bus.mul_prod;
        wb_rd_q   <= rd;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural multiplier, transaction-level
// reference model checked every cycle, and directed requests with
// hand-computed results.
module tb_mul_issue_ctrl;

  logic Clk = 1'b0;
  logic rst;
  logic busy;
  logic timeout_err;

  always #5 Clk = ~Clk;

  mul_issue_ctrl_if #(.WIDTH(16), .RD_W(4)) bus ();

  mul_issue_ctrl #(
    .WIDTH(16), .RD_W(4), .TIMEOUT(64), .ZERO_BYPASS(1)
  ) dut (
    .Clk(Clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  logic        m_run;
  logic        m_done;
  logic [15:0] m_prod;
  int          m_cnt;
  int          lat;
  logic        never_done;
  logic        hold_busy;

  always @(posedge Clk) begin
    if (rst) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (bus.mul_st && bus.mul_idle) begin
        m_run  <= 1'b1;
        m_cnt  <= lat;
        m_prod <= 16'(bus.mul_a * bus.mul_b);
      end else if (m_run) begin
        if (m_cnt == 0) begin
          if (!never_done) begin
            m_done <= 1'b1;
            m_run  <= 1'b0;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign bus.mul_idle = !m_run && !hold_busy;
  assign bus.mul_done = m_done;
  assign bus.mul_prod = m_prod;

  // ---------------- transaction model + per-cycle compare ----------------
  int          n = 0;
  logic        have = 1'b0;
  logic [15:0] t_a, t_b;
  logic [3:0]  t_rd;
  logic        t_byp, t_to, idle_a1, first_wb, prev_idle;
  int          acc_n, st_n, done_n, st_cnt, wbacc_cnt, to_cnt;
  int          st_pulses = 0, wb_hs = 0, accepts = 0;
  logic [31:0] full;

  always @(negedge Clk) begin
    n++;
    chk("busy_vs_ready", 32'(busy), 32'(!bus.req_ready));
    if (rst) begin
      have = 1'b0;
    end else begin
      if (bus.mul_st) st_pulses++;
      if (bus.wb_valid && bus.wb_ack) wb_hs++;
      if (have && n > acc_n && bus.req_ready) begin
        chk("txn_start_count", 32'(st_cnt), t_byp ? 32'd0 : 32'd1);
        chk("txn_wb_count", 32'(wbacc_cnt), (t_rd != 0 && !t_to) ? 32'd1 : 32'd0);
        chk("txn_timeout_count", 32'(to_cnt), t_to ? 32'd1 : 32'd0);
        have = 1'b0;
      end
      if (have && n > acc_n) begin
        if (n == acc_n + 1) idle_a1 = bus.mul_idle;
        chk("mul_a_held", 32'(bus.mul_a), 32'(t_a));
        chk("mul_b_held", 32'(bus.mul_b), 32'(t_b));
        if (bus.mul_st) begin
          st_cnt++;
          st_n = n;
          chk("start_after_idle", 32'(prev_idle), 32'd1);
          if (idle_a1) chk("start_latency", 32'(n - acc_n), 32'd2);
        end
        if (bus.mul_done && st_cnt > 0 && done_n < 0) done_n = n;
        if (bus.wb_valid) begin
          full = 32'(t_a) * 32'(t_b);
          chk("wb_rd", 32'(bus.wb_rd), 32'(t_rd));
          chk("wb_data", 32'(bus.wb_data), 32'(full[15:0]));
          chk("wb_allowed", 32'(t_rd != 0 && !t_to), 32'd1);
          if (first_wb) begin
            if (t_byp) chk("bypass_wb_latency", 32'(n - acc_n), 32'd1);
            else       chk("done_wb_latency", 32'(n - done_n), 32'd1);
            first_wb = 1'b0;
          end
          if (bus.wb_ack) wbacc_cnt++;
        end
        if (timeout_err) begin
          to_cnt++;
          chk("timeout_run_cycles", 32'(n - st_n), 32'd64);
        end
      end else if (!have) begin
        chk("idle_mul_st", 32'(bus.mul_st), 32'd0);
        chk("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("idle_timeout", 32'(timeout_err), 32'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        accepts++;
        have      = 1'b1;
        acc_n     = n;
        t_a       = bus.req_a;
        t_b       = bus.req_b;
        t_rd      = bus.req_rd;
        t_byp     = (bus.req_a == 0) || (bus.req_b == 0);
        t_to      = never_done && !t_byp;
        st_cnt    = 0;
        wbacc_cnt = 0;
        to_cnt    = 0;
        done_n    = -1;
        first_wb  = 1'b1;
        idle_a1   = 1'b0;
      end
    end
    prev_idle = bus.mul_idle;
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
    logic ok;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rd    = rd;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("request_accepted", 32'(ok), 32'd1);
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wb(output logic [3:0] rd, output logic [15:0] d);
    logic ok;
    ok = 1'b0;
    rd = '0;
    d  = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.wb_valid) begin
        ok = 1'b1;
        rd = bus.wb_rd;
        d  = bus.wb_data;
        break;
      end
    end
    chk("wb_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_returns", 32'(ok), 32'd1);
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  rd;
    logic [15:0] d;
    logic        ok;
    int          s0, w0, a0, n0;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_rd = '0;
    bus.wb_ack = 1'b1;
    lat = 3;
    never_done = 1'b0;
    hold_busy = 1'b0;
    repeat (3) @(posedge Clk);
    #1 rst = 1'b0;

    @(negedge Clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_st", 32'(bus.mul_st), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_mul_a", 32'(bus.mul_a), 32'd0);
    chk("rst_mul_b", 32'(bus.mul_b), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
    @(posedge Clk); #1;

    // 7x7 -> r3
    s0 = st_pulses;
    send(16'd7, 16'd7, 4'd3);
    wait_wb(rd, d);
    chk("t1_wb_rd", 32'(rd), 32'd3);
    chk("t1_wb_data", 32'(d), 32'd49);
    wait_ready();
    chk("t1_start_pulses", 32'(st_pulses - s0), 32'd1);

    // 65535x3 -> r5
    send(16'hFFFF, 16'd3, 4'd5);
    wait_wb(rd, d);
    chk("t2_wb_rd", 32'(rd), 32'd5);
    chk("t2_wb_data", 32'(d), 32'hFFFD);
    wait_ready();

    // 30000x4000 -> r7, low 16 bits of 120000000
    send(16'd30000, 16'd4000, 4'd7);
    wait_wb(rd, d);
    chk("t3_wb_rd", 32'(rd), 32'd7);
    chk("t3_wb_data", 32'(d), 32'h0E00);
    wait_ready();

    // zero-operand bypass
    s0 = st_pulses;
    send(16'h1234, 16'd0, 4'd2);
    wait_wb(rd, d);
    chk("t4_wb_rd", 32'(rd), 32'd2);
    chk("t4_wb_data", 32'(d), 32'd0);
    wait_ready();
    chk("t4_start_pulses", 32'(st_pulses - s0), 32'd0);

    // rd=0 discard
    s0 = st_pulses;
    w0 = wb_hs;
    send(16'd5, 16'd2, 4'd0);
    wait_ready();
    chk("t5_start_pulses", 32'(st_pulses - s0), 32'd1);
    chk("t5_wb_count", 32'(wb_hs - w0), 32'd0);

    // multiplier busy on arrival
    hold_busy = 1'b1;
    s0 = st_pulses;
    send(16'd6, 16'd7, 4'd9);
    repeat (6) @(negedge Clk);
    chk("t6_no_start_while_busy", 32'(st_pulses - s0), 32'd0);
    @(posedge Clk); #1;
    hold_busy = 1'b0;
    wait_wb(rd, d);
    chk("t6_wb_rd", 32'(rd), 32'd9);
    chk("t6_wb_data", 32'(d), 32'd42);
    wait_ready();

    // writeback backpressure with a second request held
    bus.wb_ack = 1'b0;
    a0 = accepts;
    send(16'd5, 16'd2, 4'd4);
    bus.req_a = 16'd9;
    bus.req_b = 16'd9;
    bus.req_rd = 4'd6;
    bus.req_valid = 1'b1;
    wait_wb(rd, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("t7_hold_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("t7_hold_wb_rd", 32'(bus.wb_rd), 32'd4);
      chk("t7_hold_wb_data", 32'(bus.wb_data), 32'd10);
      chk("t7_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    bus.wb_ack = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("t7_ack_ready", 32'(bus.req_ready), 32'd1);
    chk("t7_ack_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("t7_single_accept", 32'(accepts - a0), 32'd1);
    @(posedge Clk); #1;

    // watchdog: multiplier never finishes
    never_done = 1'b1;
    w0 = wb_hs;
    send(16'd3, 16'd3, 4'd1);
    ok = 1'b0;
    n0 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.mul_st) n0 = n;
      if (timeout_err) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t8_timeout_seen", 32'(ok), 32'd1);
    chk("t8_timeout_cycles", 32'(n - n0), 32'd64);
    wait_ready();
    chk("t8_no_wb", 32'(wb_hs - w0), 32'd0);
    never_done = 1'b0;
    rst = 1'b1;
    @(posedge Clk); #1;
    rst = 1'b0;

    // reset in the middle of RUN, then a normal multiply
    lat = 20;
    send(16'd7, 16'd7, 4'd3);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.mul_st) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t9_start_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge Clk);
    @(posedge Clk); #1;
    rst = 1'b1;
    @(posedge Clk); #1;
    rst = 1'b0;
    @(negedge Clk);
    chk("t9_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("t9_rst_busy", 32'(busy), 32'd0);
    chk("t9_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("t9_rst_mul_st", 32'(bus.mul_st), 32'd0);
    chk("t9_rst_mul_a", 32'(bus.mul_a), 32'd0);
    chk("t9_rst_wb_data", 32'(bus.wb_data), 32'd0);
    @(posedge Clk); #1;
    lat = 3;
    send(16'd7, 16'd7, 4'd3);
    wait_wb(rd, d);
    chk("t9_wb_rd", 32'(rd), 32'd3);
    chk("t9_wb_data", 32'(d), 32'd49);
    wait_ready();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
